reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 5 +
 rtl/pend_popcount.sv | 14 +
 rtl/reg_file_sb.sv | 90 +++++++++
 tb/tb_reg_file_sb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared defaults for the scoreboarded register file.
package reg_file_sb_pkg;
    localparam int WORD_LEN          = 32;
    localparam int REG_FILE_ADDR_LEN = 4;
endpackage

// File: rtl/pend_popcount.sv
// Combinational population count of the pending-register vector.
module pend_popcount #(
    parameter int N = 16
) (
    input  logic [N-1:0]       vec,
    output logic [$clog2(N):0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + {{$clog2(N){1'b0}}, vec[i]};
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// Register file with per-register pending (scoreboard) bits and a pending count.
// Optional same-cycle write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_sb #(
    parameter int WORD_LEN = reg_file_sb_pkg::WORD_LEN,
    parameter int ADDR_LEN = reg_file_sb_pkg::REG_FILE_ADDR_LEN,
    parameter int NUM_RD   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_LEN-1:0]   rd_addr,
    output logic [NUM_RD*WORD_LEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         wr_en,
    input  logic [ADDR_LEN-1:0]          wr_addr,
    input  logic [WORD_LEN-1:0]          wr_data,
    input  logic                         claim_en,
    input  logic [ADDR_LEN-1:0]          claim_addr,
    output logic [ADDR_LEN:0]            pend_cnt
);
    import reg_file_sb_pkg::*;

    localparam int DEPTH = 2 ** ADDR_LEN;

    logic [WORD_LEN-1:0] mem [DEPTH];
    logic [DEPTH-1:0]    pend;
    logic [DEPTH-1:0]    pend_next;
    logic [ADDR_LEN:0]   cnt_next;
    logic                wr_ok;
    logic                claim_ok;

    // Register 0 is hardwired: its writes and claims never take effect.
    assign wr_ok    = wr_en && (wr_addr != '0);
    assign claim_ok = claim_en && (claim_addr != '0);

    always_comb begin
        pend_next = pend;
        if (wr_ok) begin
            pend_next[wr_addr] = 1'b0;
        end
        // Claim applied last so a new producer outranks a retiring one.
        if (claim_ok) begin
            pend_next[claim_addr] = 1'b1;
        end
    end

    pend_popcount #(
        .N (DEPTH)
    ) u_popcount (
        .vec   (pend_next),
        .count (cnt_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
            pend     <= pend_next;
            pend_cnt <= cnt_next;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_LEN-1:0] addr;
        logic [WORD_LEN-1:0] data;
        logic                busy;

        assign addr = rd_addr[k*ADDR_LEN +: ADDR_LEN];

        always_comb begin
            data = (addr == '0) ? '0 : mem[addr];
            busy = pend[addr];
`ifdef REG_FILE_BYPASS_EN
            if (wr_ok && (wr_addr == addr)) begin
                data = wr_data;
                busy = claim_ok && (claim_addr == addr);
            end
`endif
        end

        assign rd_data[k*WORD_LEN +: WORD_LEN] = data;
        assign rd_busy[k]                      = busy;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: expectations queued at drive time, popped at sample time.
module tb_reg_file_sb;
    localparam int WL = 32;
    localparam int AL = 4;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*AL-1:0] rd_addr;
    logic [NR*WL-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             wr_en;
    logic [AL-1:0]    wr_addr;
    logic [WL-1:0]    wr_data;
    logic             claim_en;
    logic [AL-1:0]    claim_addr;
    logic [AL:0]      pend_cnt;

    reg_file_sb #(.WORD_LEN(WL), .ADDR_LEN(AL), .NUM_RD(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .pend_cnt   (pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;   // 0 data, 1 busy, 2 pend_cnt
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_mem [16];
    logic [15:0] m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic push(input string tag, input int sel, input int port, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.port = port; e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic flush();
        exp_t        e;
        logic [31:0] got;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                0:       got = rd_data[e.port*WL +: WL];
                1:       got = {31'b0, rd_busy[e.port]};
                default: got = {27'b0, pend_cnt};
            endcase
            chk(e.tag, got, e.exp);
        end
    endtask

    // Expect port p reading register a to match the bench model.
    task automatic push_model(input string tag, input int p, input int a);
        push({tag, "_data"}, 0, p, (a == 0) ? 32'h0 : m_mem[a]);
        push({tag, "_busy"}, 1, p, {31'b0, m_pend[a]});
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {a1[AL-1:0], a0[AL-1:0]};
    endtask

    task automatic idle();
        wr_en = 1'b0; claim_en = 1'b0; rst = 1'b0;
    endtask

    // One clock: update the model from the inputs sampled at the edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
            m_pend = '0;
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (claim_en && claim_addr != 0) m_pend[claim_addr] = 1'b1;
        end
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0; claim_addr = '0;
        m_pend = '0;
        cycle();

        // Reset state across every address
        push("rst_cnt", 2, 0, 32'd0);
        for (int a = 0; a < 16; a++) begin
            set_rd(a, 15 - a);
            push("rst_d0", 0, 0, 32'h0); push("rst_b0", 1, 0, 32'h0);
            push("rst_d1", 0, 1, 32'h0); push("rst_b1", 1, 1, 32'h0);
            flush();
        end

        // Write r5, read on both ports; write to r0 is ignored
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
        cycle();
        set_rd(5, 5);
        push("r5_p0", 0, 0, 32'hDEADBEEF); push("r5_p1", 0, 1, 32'hDEADBEEF);
        flush();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h1234;
        cycle();
        set_rd(0, 0);
        push("r0_p0", 0, 0, 32'h0); push("r0_b0", 1, 0, 32'h0); push("r0_p1", 0, 1, 32'h0);
        flush();

        // Claim r3 then r7; retire r3
        claim_en = 1'b1; claim_addr = 4'd3; cycle();
        claim_en = 1'b1; claim_addr = 4'd7; cycle();
        set_rd(3, 7);
        push("cnt2", 2, 0, 32'd2); push("busy_r3", 1, 0, 32'd1); push("busy_r7", 1, 1, 32'd1);
        flush();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h33; cycle();
        push("cnt1", 2, 0, 32'd1); push("r3_free", 1, 0, 32'd0); push("r3_data", 0, 0, 32'h33);
        flush();

        // Re-claim an already pending register; claim of r0 ignored
        claim_en = 1'b1; claim_addr = 4'd7; cycle();
        push("reclaim_cnt", 2, 0, 32'd1);
        flush();
        claim_en = 1'b1; claim_addr = 4'd0; cycle();
        set_rd(0, 7);
        push("claim0_cnt", 2, 0, 32'd1); push("claim0_busy", 1, 0, 32'd0);
        flush();

        // Claim and write r4 together: claim wins, data lands
        claim_en = 1'b1; claim_addr = 4'd4; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'hAA;
        cycle();
        set_rd(4, 4);
        push("r4_data", 0, 0, 32'hAA); push("r4_busy", 1, 1, 32'd1); push("r4_cnt", 2, 0, 32'd2);
        flush();

        // Same-cycle read of r9 during its write
        set_rd(9, 5);
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h55;
`ifdef REG_FILE_BYPASS_EN
        push("byp_r9", 0, 0, 32'h55);
`else
        push("byp_r9", 0, 0, 32'h0);
`endif
        push("byp_r9_busy", 1, 0, 32'd0); push("byp_r5", 0, 1, 32'hDEADBEEF);
        flush();
        cycle();
        push("r9_after", 0, 0, 32'h55);
        flush();

        // Write to pending r7 while also claiming it, read in the same cycle
        set_rd(7, 7);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h77; claim_en = 1'b1; claim_addr = 4'd7;
`ifdef REG_FILE_BYPASS_EN
        push("byp_r7", 0, 0, 32'h77);
`else
        push("byp_r7", 0, 0, 32'h0);
`endif
        push("byp_r7_busy", 1, 0, 32'd1);
        flush();
        cycle();

        // Claim every register, then reset with a write pending
        for (int a = 1; a < 16; a++) begin
            claim_en = 1'b1; claim_addr = a[AL-1:0]; cycle();
        end
        push("cnt_full", 2, 0, 32'd15);
        flush();
        rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'hFFFF_FFFF;
        claim_en = 1'b1; claim_addr = 4'd2;
        cycle();
        push("rst2_cnt", 2, 0, 32'd0);
        for (int a = 0; a < 16; a++) begin
            set_rd(a, a);
            push("rst2_d", 0, 0, 32'h0); push("rst2_b", 1, 1, 32'h0);
            flush();
        end

        // Random traffic against the model, sampled after each edge
        for (int n = 0; n < 60; n++) begin
            wr_en = 1'($urandom_range(0, 1)); wr_addr = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            claim_en = 1'($urandom_range(0, 1)); claim_addr = 4'($urandom_range(0, 15));
            cycle();
            set_rd($urandom_range(0, 15), $urandom_range(0, 15));
            push_model("rnd_p0", 0, int'(rd_addr[AL-1:0]));
            push_model("rnd_p1", 1, int'(rd_addr[2*AL-1:AL]));
            push("rnd_cnt", 2, 0, $countones(m_pend));
            flush();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
